// File: rtl/instruction_loader.sv
// Byte-stream loader for the 64-word instruction memory: count header, then little-endian words.
// Define CHECKSUM_EN to add a trailing XOR checksum byte and the checksum_err flag.
module instruction_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              overflow,
    output logic              checksum_err
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        ASSEMBLE,
        WRITE,
        CHECK,
        DONE
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state;
    logic [7:0]  word_total;
    logic [7:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic        accept;
    logic        last_word;

    assign byte_ready = (state == COUNT) || (state == ASSEMBLE) || (state == CHECK);
    assign accept     = byte_valid && byte_ready;
    assign last_word  = (word_cnt == word_total - 8'd1);

`ifdef CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum         <= 8'h00;
            checksum_err <= 1'b0;
        end else if (state == IDLE && load_start) begin
            csum         <= 8'h00;
            checksum_err <= 1'b0;
        end else if (state == ASSEMBLE && accept) begin
            csum <= csum ^ byte_data;
        end else if (state == CHECK && accept) begin
            checksum_err <= (byte_data != csum);
        end
    end
`else
    assign checksum_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word_total  <= 8'd0;
            word_cnt    <= 8'd0;
            byte_cnt    <= 2'd0;
            partial     <= 24'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= 32'd0;
            cpu_hold    <= 1'b0;
            load_done   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state       <= COUNT;
                        cpu_hold    <= 1'b1;
                        mem_wr_addr <= '0;
                        word_cnt    <= 8'd0;
                        byte_cnt    <= 2'd0;
                        overflow    <= 1'b0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        word_total <= byte_data;
                        if (byte_data == 8'd0) begin
                            state <= END_STATE;
                        end else begin
                            overflow <= (int'(byte_data) > DEPTH);
                            state    <= ASSEMBLE;
                        end
                    end
                end
                ASSEMBLE: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: partial[7:0]   <= byte_data;
                            2'd1: partial[15:8]  <= byte_data;
                            2'd2: partial[23:16] <= byte_data;
                            default: begin
                                mem_wr_data <= {byte_data, partial};
                                // words past the end of memory are drained but never written
                                mem_wr_en   <= (int'(word_cnt) < DEPTH);
                                state       <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    mem_wr_addr <= mem_wr_addr + 1'b1;
                    word_cnt    <= word_cnt + 8'd1;
                    state       <= last_word ? END_STATE : ASSEMBLE;
                end
                CHECK: begin
                    if (accept) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: header load, backpressure, zero count, overflow, reset abort.
`timescale 1ns/1ps
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr_en;
    logic [5:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        overflow;
    logic        checksum_err;

`ifdef CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    instruction_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .overflow     (overflow),
        .checksum_err (checksum_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          wr_cyc[$];
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cyc[$];
    int          rdy_in_write;
    int          hold_low_in_write;
    int          acc_edges[$];
    logic [7:0]  stream[$];
    bit          timed_out;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(mem_wr_addr));
            wr_data.push_back(mem_wr_data);
            if (byte_ready) rdy_in_write++;
            if (!cpu_hold) hold_low_in_write++;
        end
        if (load_done) done_cyc.push_back(cyc);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();
        rdy_in_write = 0;
        hold_low_in_write = 0;
    endtask

    task automatic start_session;
        load_start = 1'b1;
        step;
        load_start = 1'b0;
    endtask

    task automatic push_ck;
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < stream.size(); i++) x = x ^ stream[i];
        if (CK) stream.push_back(x);
    endtask

    // Offers stream bytes one per cycle (or every other cycle); logs accepting edges
    task automatic send_bytes(input bit toggle);
        int idx;
        int budget;
        bit ph;
        idx = 0;
        budget = 3000;
        ph = 1'b1;
        acc_edges.delete();
        timed_out = 1'b0;
        while (idx < stream.size() && budget > 0) begin
            byte_valid = toggle ? ph : 1'b1;
            byte_data  = stream[idx];
            if (byte_valid && byte_ready) begin
                acc_edges.push_back(cyc + 1);
                idx++;
            end
            step;
            ph = !ph;
            budget--;
        end
        byte_valid = 1'b0;
        if (idx < stream.size()) timed_out = 1'b1;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < 50) begin
            step;
            n++;
        end
        step;
        step;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        step;
        step;
        checks++;
        if ({byte_ready, mem_wr_en, cpu_hold, load_done, overflow, checksum_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {byte_ready, mem_wr_en, cpu_hold, load_done, overflow, checksum_err});
        end
        checks++;
        if (mem_wr_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", mem_wr_addr);
        end
        reset = 1'b0;
        step;
        checks++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_hold got %b%b want 00", byte_ready, cpu_hold);
        end
    endtask

    task automatic test_header_load(input bit toggle);
        clear_logs();
        stream = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        push_ck();
        start_session();
        checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL t%0d_hold_rise got %b%b want 11", toggle, cpu_hold, byte_ready);
        end
        send_bytes(toggle);
        wait_done();
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL t%0d_stream_timeout got stalled want all bytes", toggle);
        end
        checks++;
        if (wr_cyc.size() != 2) begin
            errors++;
            $display("FAIL t%0d_write_count got %0d want 2", toggle, wr_cyc.size());
        end else begin
            checks++;
            if (wr_addr[0] != 0 || wr_data[0] !== 32'h0000_0013) begin
                errors++;
                $display("FAIL t%0d_word0 got %0d:%h want 0:00000013", toggle, wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] != 1 || wr_data[1] !== 32'h0010_0093) begin
                errors++;
                $display("FAIL t%0d_word1 got %0d:%h want 1:00100093", toggle, wr_addr[1], wr_data[1]);
            end
            checks++;
            if (acc_edges.size() >= 9 && (wr_cyc[0] != acc_edges[4] || wr_cyc[1] != acc_edges[8])) begin
                errors++;
                $display("FAIL t%0d_write_latency got %0d,%0d want %0d,%0d",
                         toggle, wr_cyc[0], wr_cyc[1], acc_edges[4], acc_edges[8]);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL t%0d_done_pulses got %0d want 1", toggle, done_cyc.size());
        end else if (acc_edges.size() == stream.size()) begin
            checks++;
            if (done_cyc[0] != (CK ? acc_edges[9] + 1 : acc_edges[8] + 2)) begin
                errors++;
                $display("FAIL t%0d_done_cycle got %0d want %0d", toggle, done_cyc[0],
                         CK ? acc_edges[9] + 1 : acc_edges[8] + 2);
            end
        end
        checks++;
        if (rdy_in_write != 0 || hold_low_in_write != 0) begin
            errors++;
            $display("FAIL t%0d_write_ready_hold got %0d,%0d want 0,0", toggle, rdy_in_write, hold_low_in_write);
        end
        checks++;
        if (cpu_hold !== 1'b0 || overflow !== 1'b0 || checksum_err !== 1'b0) begin
            errors++;
            $display("FAIL t%0d_end_flags got %b%b%b want 000", toggle, cpu_hold, overflow, checksum_err);
        end
    endtask

    task automatic test_zero_count;
        clear_logs();
        stream = '{8'h00};
        push_ck();
        start_session();
        send_bytes(1'b0);
        wait_done();
        checks++;
        if (wr_cyc.size() != 0) begin
            errors++;
            $display("FAIL zero_writes got %0d want 0", wr_cyc.size());
        end
        checks++;
        if (done_cyc.size() != 1 || acc_edges.size() != stream.size()) begin
            errors++;
            $display("FAIL zero_done_pulses got %0d want 1", done_cyc.size());
        end else if (done_cyc[0] != acc_edges[acc_edges.size() - 1] + 1) begin
            errors++;
            $display("FAIL zero_done_cycle got %0d want %0d", done_cyc[0], acc_edges[acc_edges.size() - 1] + 1);
        end
    endtask

    task automatic test_overflow;
        int bad;
        logic [7:0] b;
        clear_logs();
        start_session();
        stream = '{8'h41};
        send_bytes(1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag_after_header got %b want 1", overflow);
        end
        stream = '{8'h41};
        for (int i = 0; i < 65; i++) begin
            b = 8'(i);
            stream.push_back(b);
            stream.push_back(8'h5A);
            stream.push_back(8'h00);
            stream.push_back(b);
        end
        push_ck();
        void'(stream.pop_front());
        send_bytes(1'b0);
        wait_done();
        checks++;
        if (timed_out || wr_cyc.size() != 64) begin
            errors++;
            $display("FAIL ovf_write_count got %0d want 64", wr_cyc.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                b = 8'(i);
                if (wr_addr[i] != i || wr_data[i] !== {b, 8'h00, 8'h5A, b}) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ovf_write_content got %0d bad words want 0", bad);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done got %0d pulses ovf=%b want 1 pulse ovf=1", done_cyc.size(), overflow);
        end
    endtask

    task automatic test_reset_mid;
        clear_logs();
        stream = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start_session();
        send_bytes(1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({byte_ready, mem_wr_en, cpu_hold, load_done} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_outputs got %b want 0000", {byte_ready, mem_wr_en, cpu_hold, load_done});
        end
        step;
        reset = 1'b0;
        step;
        step;
        checks++;
        if (wr_cyc.size() != 1 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL midrst_activity got %0d writes %0d done want 1 0", wr_cyc.size(), done_cyc.size());
        end
        clear_logs();
        stream = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        push_ck();
        start_session();
        send_bytes(1'b0);
        wait_done();
        checks++;
        if (wr_cyc.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL midrst_resume got %0d writes %0d done want 1 1", wr_cyc.size(), done_cyc.size());
        end else if (wr_addr[0] != 0 || wr_data[0] !== 32'hDDCC_BBAA) begin
            errors++;
            $display("FAIL midrst_resume_word got %0d:%h want 0:ddccbbaa", wr_addr[0], wr_data[0]);
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] ckb[2];
        ckb[0] = 8'h44;
        ckb[1] = 8'h45;
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            stream = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
            stream.push_back(ckb[k]);
            start_session();
            send_bytes(1'b0);
            wait_done();
            checks++;
            if (checksum_err !== (k == 1)) begin
                errors++;
                $display("FAIL ck%0d_err got %b want %0d", k, checksum_err, k);
            end
            checks++;
            if (done_cyc.size() != 1 || wr_cyc.size() != 1) begin
                errors++;
                $display("FAIL ck%0d_done got %0d done %0d writes want 1 1", k, done_cyc.size(), wr_cyc.size());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_header_load(1'b0);
        test_header_load(1'b1);
        test_zero_count();
        test_overflow();
        test_reset_mid();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
